card_hand_dealer: RTL

// - Upstream of the 7-segment card decoder: deals cards into one hand and holds up to three card codes.
// - Each card slot output drives one decoder directly. Codes: 0=blank, 1=A, 2..9, 10, 11=J, 12=Q, 13=K.
// - A free-running 1..13 counter is the card source. A deal request samples it.
// - Also keeps the hand's baccarat score, registered.

---
 rtl/card_hand_dealer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/card_hand_dealer.sv
// Deals cards from a free-running 1..CARD_MAX counter into a three-slot hand and keeps its baccarat score.
// Card lands one edge after acceptance, score/deal_done one edge later; deal_ready drops while full, clearing or pending.
`timescale 1ns/1ps
module card_hand_dealer #(
  parameter int CARD_MAX  = 13,
  parameter int MAX_CARDS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       deal_req,
  output logic       deal_ready,
  output logic [3:0] card1,
  output logic [3:0] card2,
  output logic [3:0] card3,
  output logic [1:0] num_cards,
  output logic [3:0] score,
  output logic       deal_done,
  output logic [3:0] deal_value
);

  generate
    if (MAX_CARDS != 3) begin : g_bad_max_cards
      $error("card_hand_dealer: MAX_CARDS must be 3");
    end
    if (CARD_MAX < 1 || CARD_MAX > 15) begin : g_bad_card_max
      $error("card_hand_dealer: CARD_MAX must fit a 4-bit card code");
    end
  endgenerate

  localparam logic [3:0] CARD_TOP = 4'(CARD_MAX);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FULL  = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       pending_q;
  logic [3:0] counter_q;
  logic       accept;
  logic [4:0] pts_sum;
  logic [3:0] score_next;

  function automatic logic [4:0] pts(input logic [3:0] code);
    return (code >= 4'd1 && code <= 4'd9) ? {1'b0, code} : 5'd0;
  endfunction

  assign accept     = deal_req && deal_ready;
  assign deal_value = counter_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = EMPTY;
    end else if (accept) begin
      case (state_q)
        EMPTY:   state_d = ONE;
        ONE:     state_d = TWO;
        TWO:     state_d = FULL;
        default: state_d = FULL;
      endcase
    end
  end

  always_comb begin
    deal_ready = (state_q != FULL) && !clear && !pending_q;
    num_cards  = state_q;
  end

  // Card source runs regardless of clear or dealing activity.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter_q <= 4'd1;
    end else if (counter_q == CARD_TOP) begin
      counter_q <= 4'd1;
    end else begin
      counter_q <= counter_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      card1 <= 4'd0;
      card2 <= 4'd0;
      card3 <= 4'd0;
    end else if (accept) begin
      case (state_q)
        EMPTY:   card1 <= counter_q;
        ONE:     card2 <= counter_q;
        TWO:     card3 <= counter_q;
        default: ;
      endcase
    end
  end

  // Sum of three points is at most 27, so two conditional subtracts give mod 10.
  always_comb begin
    pts_sum = pts(card1) + pts(card2) + pts(card3);
    if (pts_sum >= 5'd20) begin
      score_next = 4'(pts_sum - 5'd20);
    end else if (pts_sum >= 5'd10) begin
      score_next = 4'(pts_sum - 5'd10);
    end else begin
      score_next = 4'(pts_sum);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      pending_q <= 1'b0;
      deal_done <= 1'b0;
      score     <= 4'd0;
    end else begin
      pending_q <= accept;
      deal_done <= pending_q;
      if (pending_q) begin
        score <= score_next;
      end
    end
  end

endmodule
